// File: rtl/bridge_pkg.sv
// bridge_pkg: shared mailbox constants, offsets and host-interface state type.
package bridge_pkg;
  localparam logic [15:0] CMD_MAGIC = 16'h434D;
  localparam logic [15:0] OK_MAGIC = 16'h6F6B;
  localparam logic [7:0] STATUS_OFS = 8'h00;
  localparam logic [7:0] PARAM_OFS = 8'h20;
  localparam logic [7:0] RESP_OFS = 8'h40;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} cmd_host_state_e;
endpackage

// File: rtl/bridge_word_regfile.sv
// bridge_word_regfile: N x 32 register bank, per-word write enable, registered read.
module bridge_word_regfile
  import bridge_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    we,
  input  logic [N*32-1:0] wdata,
  input  logic            rd,
  input  logic [2:0]      rd_idx,
  output logic [N*32-1:0] words,
  output logic [31:0]     rd_data
);
  logic [31:0] mem_q [N];
  logic [31:0] mem_d [N];
  logic [31:0] rd_data_q, rd_data_d;
  always_comb begin
    for (int i = 0; i < int'(N); i++) mem_d[i] = we[i] ? wdata[i*32+:32] : mem_q[i];
    rd_data_d = rd ? mem_q[rd_idx] : rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N); i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) mem_q[i] <= mem_d[i];
      rd_data_q <= rd_data_d;
    end
  end
  for (genvar g = 0; g < int'(N); g++) begin : g_words
    assign words[g*32+:32] = mem_q[g];
  end
  assign rd_data = rd_data_q;
endmodule

// File: rtl/bridge_cmd_host_if.sv
// bridge_cmd_host_if: host mailbox on the bridge bus; issues one command to the driver
// and posts its result/response words back for the host to poll.
module bridge_cmd_host_if
  import bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hF800_1000,
  parameter int unsigned PARAM_WORDS = 8,
  parameter int unsigned RESP_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              bridge_addr,
  input  logic                     bridge_wr,
  input  logic [31:0]              bridge_wr_data,
  input  logic                     bridge_rd,
  output logic [31:0]              bridge_rd_data,
  output logic                     cmd_valid,
  output logic [15:0]              cmd_word,
  output logic [PARAM_WORDS*32-1:0] cmd_param,
  input  logic                     cmd_done,
  input  logic [15:0]              cmd_result,
  input  logic [RESP_WORDS*32-1:0] cmd_response,
  output logic                     busy
);
  cmd_host_state_e state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [15:0] cmd_word_q, cmd_word_d;
  logic [31:0] rd_loc_q, rd_loc_d;
  logic [1:0] src_q, src_d;
  logic [7:0] ofs;
  logic hit, st_sel, p_sel, r_sel, done_acc;
  logic [PARAM_WORDS-1:0] p_we;
  logic [31:0] p_rd, r_rd;
  assign ofs = bridge_addr[7:0];
  assign hit = (bridge_addr & ~32'hFF) == BASE_ADDR;
  assign st_sel = hit && ofs == STATUS_OFS;
  assign p_sel = hit && ofs[7:5] == PARAM_OFS[7:5] && ofs[1:0] == 2'b00 && 32'(ofs[4:2]) < PARAM_WORDS;
  assign r_sel = hit && ofs[7:5] == RESP_OFS[7:5] && ofs[1:0] == 2'b00 && 32'(ofs[4:2]) < RESP_WORDS;
  // done is only honoured in WAIT, so a pulse during ISSUE or after reset is dropped
  assign done_acc = state_q == WAIT && cmd_done;
  assign p_we = (bridge_wr && p_sel && state_q == IDLE) ? PARAM_WORDS'(1) << ofs[4:2] : '0;
  always_comb begin
    state_d = state_q;
    status_d = status_q;
    cmd_word_d = cmd_word_q;
    if (state_q == IDLE && bridge_wr && st_sel && bridge_wr_data[31:16] == CMD_MAGIC) begin
      state_d = ISSUE;
      status_d = bridge_wr_data;
      cmd_word_d = bridge_wr_data[15:0];
    end else if (state_q == ISSUE) begin
      state_d = WAIT;
    end else if (done_acc) begin
      state_d = IDLE;
      status_d = {OK_MAGIC, cmd_result};
    end
    src_d = bridge_rd ? (p_sel ? 2'd1 : r_sel ? 2'd2 : 2'd0) : src_q;
    rd_loc_d = bridge_rd ? (st_sel ? status_q : 32'h0) : rd_loc_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      status_q <= '0;
      cmd_word_q <= '0;
      rd_loc_q <= '0;
      src_q <= '0;
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      cmd_word_q <= cmd_word_d;
      rd_loc_q <= rd_loc_d;
      src_q <= src_d;
    end
  end
  bridge_word_regfile #(.N(PARAM_WORDS)) u_param (
    .clk(clk), .reset_n(reset_n), .we(p_we), .wdata({PARAM_WORDS{bridge_wr_data}}),
    .rd(bridge_rd && p_sel), .rd_idx(ofs[4:2]), .words(cmd_param), .rd_data(p_rd)
  );
  logic [RESP_WORDS*32-1:0] resp_words;
  bridge_word_regfile #(.N(RESP_WORDS)) u_resp (
    .clk(clk), .reset_n(reset_n), .we({RESP_WORDS{done_acc}}), .wdata(cmd_response),
    .rd(bridge_rd && r_sel), .rd_idx(ofs[4:2]), .words(resp_words), .rd_data(r_rd)
  );
  assign bridge_rd_data = src_q == 2'd1 ? p_rd : src_q == 2'd2 ? r_rd : rd_loc_q;
  assign cmd_valid = state_q == ISSUE;
  assign cmd_word = cmd_word_q;
  assign busy = state_q != IDLE;
endmodule

// File: doc/bridge_cmd_host_if.md
Name: bridge_cmd_host_if

Overview:
- Upstream stage of the bridge command decoder.
- Memory-mapped slave on the APF bridge bus: holds the host command mailbox (command word, parameter words, response words).
- Detects a host write of a valid command, presents it on the driver side of bridge_driver_if as a single-cycle valid, waits for done, then writes the 'ok' status word and the response words back for the host to poll.

Parameters:
- BASE_ADDR, 32'hF800_1000, byte address of the mailbox region.
- PARAM_WORDS, 8, number of 32-bit parameter words (offsets 0x20 upward).
- RESP_WORDS, 8, number of 32-bit response words (offsets 0x40 upward).

Ports:
- clk  input  1  bridge clock (same as cmd.clk).
- reset_n  input  1  synchronous active-low reset.
- bridge_addr  input  32  bridge byte address.
- bridge_wr  input  1  write strobe, one cycle per word.
- bridge_wr_data  input  32  write data.
- bridge_rd  input  1  read strobe.
- bridge_rd_data  output  32  read data, valid 1 cycle after bridge_rd.
- cmd_valid  output  1  drives bridge_driver_if.valid.
- cmd_word  output  16  drives bridge_driver_if.word.
- cmd_param  output  PARAM_WORDS*32  drives bridge_driver_if.param, word 0 in LSBs.
- cmd_done  input  1  from bridge_driver_if.done.
- cmd_result  input  16  from bridge_driver_if.result.
- cmd_response  input  RESP_WORDS*32  from bridge_driver_if.response.
- busy  output  1  a command is outstanding.

Behaviour:
- Address decode:
  - hit = (bridge_addr & ~32'hFF) == BASE_ADDR.
  - Offset 0x00 = status/command word; 0x20+4n = param n; 0x40+4n = response n.
  - Other offsets write nothing and read 0.
- Reset: state IDLE; cmd_valid=0; busy=0; cmd_word=0; all param, response and status registers 0; bridge_rd_data=0.
- States:
  - IDLE → ISSUE on a host write to 0x00 with wr_data[31:16]==16'h434D. In the same cycle: cmd_word←wr_data[15:0]; status←wr_data.
  - A write to 0x00 without that magic is ignored (no state change, status unchanged).
  - ISSUE: cmd_valid=1 for exactly this cycle; busy=1; → WAIT.
  - WAIT: cmd_done is sampled from the cycle after ISSUE onward; it is never sampled in the ISSUE cycle.
  - WAIT, on cmd_done=1: latch response[n]←cmd_response[32n+:32] for all n; status←{16'h6F6B, cmd_result}; → IDLE; busy=0 in the following cycle.
- Minimum command latency: host write in cycle 0, cmd_valid in cycle 1, earliest status update in cycle 3 (done presented in cycle 2).
- Param writes are accepted only in IDLE. Params are frozen while busy, so cmd_param is stable from ISSUE through done.
- A host write to 0x00 or to a param offset while busy is ignored; the command is not queued.
- Response words are host-read-only; writes to them are ignored.
- Reads:
  - Registered, 1-cycle latency; bridge_rd_data holds its value until the next read.
  - Status reads {16'h434D, cmd} while busy and {16'h6F6B, result} after completion.
  - A simultaneous read and write to the same address returns the pre-write value.
- A status write in the same cycle as cmd_done (busy) is ignored; the completion update wins.
- Reset while in ISSUE or WAIT: return to IDLE, cmd_valid=0 next cycle, no status written. A late cmd_done after reset is ignored.
- PARAM_WORDS and RESP_WORDS must each be ≤ 8 so that their offsets stay inside 0x20–0x5C.

Decomposition:
- In bridge_pkg:
  - magic constants CMD_MAGIC=16'h434D and OK_MAGIC=16'h6F6B;
  - offset localparams STATUS_OFS, PARAM_OFS, RESP_OFS;
  - state enum cmd_host_state_e {IDLE, ISSUE, WAIT}.
- One sub-module, bridge_word_regfile: N×32 register bank with registered read and per-word write enable. Instantiated twice, once for params and once for responses.

Test Plan:
- Write param0=32'h0000_0003, then cmd 32'h434D_0000 (request_status); model holds done low 5 cycles then done=1, result=16'h0003 → one cmd_valid pulse, cmd_word=0, cmd_param[31:0]=3; status reads 32'h6F6B_0003; busy drops after done.
- Write 32'h1234_0010 to 0x00 → no cmd_valid, status reads its prior value.
- During WAIT, write cmd 32'h434D_0011 and param0=32'hFFFF_FFFF → both ignored; after done, cmd_word still original and param0 unchanged.
- Done with cmd_response word0=32'hDEAD_BEEF, word7=32'h0000_0001 → reads of 0x40 and 0x5C return those values one cycle after bridge_rd.
- Assert reset_n=0 during WAIT, then release and drive done=1 → state IDLE, status reads 0, no status update.
- Read an unmapped offset 0x80 and an address outside BASE_ADDR → bridge_rd_data=0; back-to-back cmd 0x434D_0002 with done asserted 1 cycle after valid → status 0x6F6B_xxxx by cycle 3.
